// File: rtl/eth_tx_arbiter.sv
// Two-source round-robin frame scheduler for the UDP/IP/Ethernet transmit path.
// Optional per-source frame and length-error counters under ETH_TX_ARB_STATS_EN.
module eth_tx_arbiter #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned MAX_LEN    = 1472
) (
    input  logic        s_axis_aclk,
    input  logic        rst,
    input  logic        s0_req,
    input  logic        s1_req,
    input  logic [15:0] s0_len,
    input  logic [15:0] s1_len,
    input  logic [15:0] s0_dst_port,
    input  logic [15:0] s1_dst_port,
    output logic        s0_grant,
    output logic        s1_grant,
    input  logic [7:0]  s0_tdata,
    input  logic [7:0]  s1_tdata,
    input  logic        s0_tvalid,
    input  logic        s1_tvalid,
    input  logic        s0_tlast,
    input  logic        s1_tlast,
    input  logic        s0_tuser,
    input  logic        s1_tuser,
    output logic        s0_tready,
    output logic        s1_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [15:0] UDP_DestPort,
    output logic [15:0] UDP_TotLen,
    output logic [15:0] IP_TotLen,
`ifdef ETH_TX_ARB_STATS_EN
    output logic [31:0] frame_cnt0,
    output logic [31:0] frame_cnt1,
    output logic [15:0] err_cnt,
`endif
    output logic        busy,
    output logic        len_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]  state;
    logic        sel;
    logic        rr_ptr;
    logic [15:0] gap_cnt;
    logic [15:0] cur_len;
    logic [15:0] cur_dst;
    logic        len_ok;
    logic        last_hs;

    assign cur_len = sel ? s1_len : s0_len;
    assign cur_dst = sel ? s1_dst_port : s0_dst_port;
    assign len_ok  = (cur_len != 16'd0) && (cur_len <= 16'(MAX_LEN));
    assign last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge s_axis_aclk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            sel          <= 1'b0;
            rr_ptr       <= 1'b0;
            gap_cnt      <= '0;
            UDP_DestPort <= '0;
            UDP_TotLen   <= '0;
            IP_TotLen    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s0_req || s1_req) begin
                        sel   <= (s0_req && s1_req) ? rr_ptr : s1_req;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (len_ok) begin
                        UDP_DestPort <= cur_dst;
                        UDP_TotLen   <= cur_len + 16'd8;
                        IP_TotLen    <= cur_len + 16'd28;
                        state        <= ST_SEND;
                    end else begin
                        // Rejected requester loses its turn so the other side is not starved.
                        rr_ptr <= ~sel;
                        state  <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (last_hs) begin
                        rr_ptr <= ~sel;
                        if (IFG_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= 16'(IFG_CYCLES - 1);
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 16'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s0_grant      = 1'b0;
        s1_grant      = 1'b0;
        len_err       = 1'b0;
        s0_tready     = 1'b0;
        s1_tready     = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        busy          = (state != ST_IDLE);
        if (state == ST_GRANT) begin
            s0_grant = ~sel;
            s1_grant = sel;
            len_err  = ~len_ok;
        end
        if (state == ST_SEND) begin
            if (sel) begin
                m_axis_tdata  = s1_tdata;
                m_axis_tvalid = s1_tvalid;
                m_axis_tlast  = s1_tlast;
                m_axis_tuser  = s1_tuser;
                s1_tready     = m_axis_tready;
            end else begin
                m_axis_tdata  = s0_tdata;
                m_axis_tvalid = s0_tvalid;
                m_axis_tlast  = s0_tlast;
                m_axis_tuser  = s0_tuser;
                s0_tready     = m_axis_tready;
            end
        end
    end

`ifdef ETH_TX_ARB_STATS_EN
    always_ff @(posedge s_axis_aclk or posedge rst) begin
        if (rst) begin
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
            err_cnt    <= '0;
        end else begin
            if (state == ST_SEND && last_hs) begin
                if (sel) begin
                    frame_cnt1 <= frame_cnt1 + 32'd1;
                end else begin
                    frame_cnt0 <= frame_cnt0 + 32'd1;
                end
            end
            if (len_err && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed self-checking bench for eth_tx_arbiter; a second instance covers IFG_CYCLES=0.
// Stats counters are checked when ETH_TX_ARB_STATS_EN is defined.
module tb_eth_tx_arbiter;

    localparam int IFG = 12;

    logic        clk;
    logic        rst;
    logic        s0_req, s1_req;
    logic [15:0] s0_len, s1_len, s0_dst, s1_dst;
    logic        s0_grant, s1_grant;
    logic [7:0]  s0_tdata, s1_tdata;
    logic        s0_tvalid, s1_tvalid, s0_tlast, s1_tlast, s0_tuser, s1_tuser;
    logic        s0_tready, s1_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic [15:0] udp_port, udp_len, ip_len;
    logic        busy, len_err;

    logic        b_s0_req, b_s0_grant, b_s1_grant;
    logic [15:0] b_s0_len, b_s0_dst;
    logic [7:0]  b_s0_tdata, b_m_tdata;
    logic        b_s0_tvalid, b_s0_tlast, b_s0_tready, b_s1_tready;
    logic        b_m_tvalid, b_m_tlast, b_m_tuser, b_m_tready;
    logic [15:0] b_udp_port, b_udp_len, b_ip_len;
    logic        b_busy, b_len_err;

`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] frame_cnt0, frame_cnt1, b_frame_cnt0, b_frame_cnt1;
    logic [15:0] err_cnt, b_err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int data_sum = 0;

    eth_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_LEN(1472)) u_dut (
        .s_axis_aclk(clk), .rst(rst),
        .s0_req(s0_req), .s1_req(s1_req),
        .s0_len(s0_len), .s1_len(s1_len),
        .s0_dst_port(s0_dst), .s1_dst_port(s1_dst),
        .s0_grant(s0_grant), .s1_grant(s1_grant),
        .s0_tdata(s0_tdata), .s1_tdata(s1_tdata),
        .s0_tvalid(s0_tvalid), .s1_tvalid(s1_tvalid),
        .s0_tlast(s0_tlast), .s1_tlast(s1_tlast),
        .s0_tuser(s0_tuser), .s1_tuser(s1_tuser),
        .s0_tready(s0_tready), .s1_tready(s1_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .UDP_DestPort(udp_port), .UDP_TotLen(udp_len), .IP_TotLen(ip_len),
`ifdef ETH_TX_ARB_STATS_EN
        .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .err_cnt(err_cnt),
`endif
        .busy(busy), .len_err(len_err)
    );

    eth_tx_arbiter #(.IFG_CYCLES(0), .MAX_LEN(1472)) u_dut_nogap (
        .s_axis_aclk(clk), .rst(rst),
        .s0_req(b_s0_req), .s1_req(1'b0),
        .s0_len(b_s0_len), .s1_len(16'd0),
        .s0_dst_port(b_s0_dst), .s1_dst_port(16'd0),
        .s0_grant(b_s0_grant), .s1_grant(b_s1_grant),
        .s0_tdata(b_s0_tdata), .s1_tdata(8'd0),
        .s0_tvalid(b_s0_tvalid), .s1_tvalid(1'b0),
        .s0_tlast(b_s0_tlast), .s1_tlast(1'b0),
        .s0_tuser(1'b0), .s1_tuser(1'b0),
        .s0_tready(b_s0_tready), .s1_tready(b_s1_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid),
        .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser),
        .m_axis_tready(b_m_tready),
        .UDP_DestPort(b_udp_port), .UDP_TotLen(b_udp_len), .IP_TotLen(b_ip_len),
`ifdef ETH_TX_ARB_STATS_EN
        .frame_cnt0(b_frame_cnt0), .frame_cnt1(b_frame_cnt1), .err_cnt(b_err_cnt),
`endif
        .busy(b_busy), .len_err(b_len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent handshake monitor on the downstream stream.
    always @(posedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            hs_cnt   <= hs_cnt + 1;
            data_sum <= data_sum + int'(m_axis_tdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int src);
        bit found = 1'b0;
        src = -1;
        for (int i = 0; i < 64 && !found; i++) begin
            if (s0_grant || s1_grant) begin
                src   = s1_grant ? 1 : 0;
                found = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("grant_excl", 32'(s0_grant & s1_grant), 32'd0);
    endtask

    task automatic send_frame(input int src, input int n, input bit bp, input logic [7:0] base);
        int   idx = 0;
        int   cyc = 0;
        logic rdy;
        while (idx < n && cyc < 4 * n + 8) begin
            rdy = bp ? cyc[0] : 1'b1;
            if (src == 0) begin
                s0_tvalid = 1'b1; s0_tdata = 8'(base + idx);
                s0_tlast = (idx == n - 1); s0_tuser = (idx == 0);
            end else begin
                s1_tvalid = 1'b1; s1_tdata = 8'(base + idx);
                s1_tlast = (idx == n - 1); s1_tuser = (idx == 0);
            end
            m_axis_tready = rdy;
            #1;
            chk("m_tdata", 32'(m_axis_tdata), 32'(8'(base + idx)));
            chk("m_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("m_tlast", 32'(m_axis_tlast), 32'(idx == n - 1));
            chk("m_tuser", 32'(m_axis_tuser), 32'(idx == 0));
            chk("sel_tready", 32'(src == 0 ? s0_tready : s1_tready), 32'(rdy));
            chk("unsel_tready", 32'(src == 0 ? s1_tready : s0_tready), 32'd0);
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        chk("frame_done", 32'(idx), 32'(n));
        s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tuser = 1'b0;
        s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tuser = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    initial begin
        int src;
        int hs0, sum0;
        rst = 1'b1;
        s0_req = 0; s1_req = 0; s0_len = 0; s1_len = 0; s0_dst = 0; s1_dst = 0;
        s0_tdata = 0; s1_tdata = 0; s0_tvalid = 0; s1_tvalid = 0;
        s0_tlast = 0; s1_tlast = 0; s0_tuser = 0; s1_tuser = 0; m_axis_tready = 0;
        b_s0_req = 0; b_s0_len = 0; b_s0_dst = 0; b_s0_tdata = 0;
        b_s0_tvalid = 0; b_s0_tlast = 0; b_m_tready = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_grants", 32'({s0_grant, s1_grant}), 32'd0);
        chk("rst_tready", 32'({s0_tready, s1_tready}), 32'd0);
        chk("rst_m", 32'({m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 32'd0);
        chk("rst_hdr", 32'(udp_port | udp_len | ip_len), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
`ifdef ETH_TX_ARB_STATS_EN
        chk("rst_stats", frame_cnt0 | frame_cnt1 | 32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);

        // IFG_CYCLES=0: second grant two cycles after the first tlast cycle
        b_s0_req = 1; b_s0_len = 16'd4; b_s0_dst = 16'h0B0B;
        @(negedge clk);
        chk("ng_grant1", 32'(b_s0_grant), 32'd1);
        @(negedge clk);
        b_s0_tvalid = 1; b_s0_tlast = 1; b_s0_tdata = 8'h77; b_m_tready = 1;
        #1;
        chk("ng_tvalid", 32'(b_m_tvalid), 32'd1);
        chk("ng_hdr", 32'(b_udp_len), 32'd12);
        @(negedge clk);
        b_s0_tvalid = 0; b_s0_tlast = 0;
        chk("ng_idle", 32'({b_busy, b_s0_grant}), 32'd0);
        @(negedge clk);
        chk("ng_grant2", 32'(b_s0_grant), 32'd1);
        b_s0_req = 0;
        @(negedge clk);
        b_s0_tvalid = 1; b_s0_tlast = 1;
        @(negedge clk);
        b_s0_tvalid = 0; b_s0_tlast = 0;
        chk("ng_done", 32'(b_busy), 32'd0);

        // Single request, grant latency, 100-byte frame, gap length
        s0_req = 1; s0_len = 16'd100; s0_dst = 16'h1234;
        #1;
        chk("t1_nogrant", 32'({s0_grant, busy}), 32'd0);
        @(negedge clk);
        chk("t1_grant", 32'({s0_grant, s1_grant}), 32'b10);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_len_err", 32'(len_err), 32'd0);
        s0_req = 0;
        @(negedge clk);
        chk("t1_port", 32'(udp_port), 32'h1234);
        chk("t1_udp", 32'(udp_len), 32'd108);
        chk("t1_ip", 32'(ip_len), 32'd128);
        send_frame(0, 100, 1'b0, 8'h00);
        s0_tvalid = 1;
        #1;
        chk("t1_gap_tvalid", 32'({m_axis_tvalid, s0_tready}), 32'd0);
        s0_tvalid = 0;
        chk("t1_hdr_hold", 32'(udp_len), 32'd108);
        repeat (IFG - 1) @(negedge clk);
        chk("t1_busy_gap", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Contention: reset first so rr_ptr favours source 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s0_req = 1; s0_len = 16'd10; s0_dst = 16'h000A;
        s1_req = 1; s1_len = 16'd20; s1_dst = 16'h000B;
        for (int g = 0; g < 4; g++) begin
            wait_grant(src);
            chk("rr_order", 32'(src), 32'(g % 2));
            @(negedge clk);
            chk("rr_udp", 32'(udp_len), (g % 2) ? 32'd28 : 32'd18);
            chk("rr_ip", 32'(ip_len), (g % 2) ? 32'd48 : 32'd38);
            chk("rr_port", 32'(udp_port), (g % 2) ? 32'h000B : 32'h000A);
            send_frame(src, 2, 1'b0, 8'(8'h10 * g));
        end
        s0_req = 0; s1_req = 0;

        // Backpressure: 64 bytes, tready toggling
        s0_req = 1; s0_len = 16'd64; s0_dst = 16'h6464;
        wait_grant(src);
        chk("bp_src", 32'(src), 32'd0);
        s0_req = 0;
        @(negedge clk);
        chk("bp_udp", 32'(udp_len), 32'd72);
        hs0 = hs_cnt; sum0 = data_sum;
        send_frame(0, 64, 1'b1, 8'h40);
        chk("bp_hs", 32'(hs_cnt - hs0), 32'd64);
        // sum over i=0..63 of (0x40+i) = 4096 + 2016
        chk("bp_sum", 32'(data_sum - sum0), 32'd6112);

        // Length errors and rr_ptr toggle on reject
        s1_req = 1; s1_len = 16'd0; s1_dst = 16'h5555;
        wait_grant(src);
        chk("e0_src", 32'(src), 32'd1);
        chk("e0_len_err", 32'(len_err), 32'd1);
        s1_req = 0;
        @(negedge clk);
        chk("e0_pulse", 32'({len_err, busy, m_axis_tvalid}), 32'd0);
        chk("e0_hdr_hold", {udp_len, ip_len}, {16'd72, 16'd92});
        chk("e0_port_hold", 32'(udp_port), 32'h6464);
        s0_req = 1; s0_len = 16'd5; s0_dst = 16'h0505;
        s1_req = 1; s1_len = 16'd1473; s1_dst = 16'h6666;
        wait_grant(src);
        chk("e1_rr_src", 32'(src), 32'd0);
        chk("e1_no_err", 32'(len_err), 32'd0);
        s0_req = 0;
        @(negedge clk);
        chk("e1_hdr", {udp_len, ip_len}, {16'd13, 16'd33});
        send_frame(0, 1, 1'b0, 8'hA0);
        wait_grant(src);
        chk("e2_src", 32'(src), 32'd1);
        chk("e2_len_err", 32'(len_err), 32'd1);
        s1_req = 0;
        @(negedge clk);
        chk("e2_idle", 32'({busy, m_axis_tvalid}), 32'd0);
        chk("e2_hdr_hold", {udp_len, ip_len}, {16'd13, 16'd33});
        chk("e2_port_hold", 32'(udp_port), 32'h0505);
        s1_req = 1; s1_len = 16'd1472; s1_dst = 16'h0FFF;
        wait_grant(src);
        chk("e3_src", 32'(src), 32'd1);
        chk("e3_no_err", 32'(len_err), 32'd0);
        s1_req = 0;
        @(negedge clk);
        chk("e3_hdr", {udp_len, ip_len}, {16'd1480, 16'd1500});
        chk("e3_port", 32'(udp_port), 32'h0FFF);
        send_frame(1, 1, 1'b0, 8'hB0);
`ifdef ETH_TX_ARB_STATS_EN
        chk("st_cnt0", frame_cnt0, 32'd4);
        chk("st_cnt1", frame_cnt1, 32'd3);
        chk("st_err", 32'(err_cnt), 32'd2);
`endif

        // Reset mid-frame while rr_ptr points at source 1
        s0_req = 1; s0_len = 16'd3;
        wait_grant(src);
        s0_req = 0;
        @(negedge clk);
        send_frame(0, 1, 1'b0, 8'hC0);
        s1_req = 1; s1_len = 16'd7;
        wait_grant(src);
        chk("mr_src", 32'(src), 32'd1);
        s1_req = 0;
        @(negedge clk);
        s1_tvalid = 1; s1_tdata = 8'hD0;
        #1;
        chk("mr_tvalid", 32'(m_axis_tvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_m", 32'({m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 32'd0);
        chk("mr_tready", 32'({s0_tready, s1_tready}), 32'd0);
        chk("mr_busy", 32'({busy, len_err, s0_grant, s1_grant}), 32'd0);
        chk("mr_hdr", 32'(udp_port | udp_len | ip_len), 32'd0);
`ifdef ETH_TX_ARB_STATS_EN
        chk("mr_stats", frame_cnt0 | frame_cnt1 | 32'(err_cnt), 32'd0);
`endif
        s1_tvalid = 0;
        @(negedge clk);
        rst = 1'b0;
        s0_req = 1; s1_req = 1; s0_len = 16'd3; s1_len = 16'd7;
        wait_grant(src);
        chk("mr_rr_reset", 32'(src), 32'd0);
        s0_req = 0; s1_req = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
